cross_bar_route_demux: RTL and testbench
========================================

# cross_bar_route_demux

Single-input, multi-output AXI-Stream packet router for the switch ingress side, the inverse of the Nx1 packet arbiter. It decodes a destination index from the first beat (header) of each packet and steers the whole packet, through one registered output stage, to exactly one of `CHANNEL_NO` master ports. Routing is locked for the packet's duration and released on the `tlast` beat.

## Interface
Parameters:
- `MSEL_WIDTH`, default 1: destination index width.
- `CHANNEL_NO`, default `2**MSEL_WIDTH`: number of master ports.
- `DATA_WIDTH`, default 32: tdata width; must be ≥ `MSEL_WIDTH`.

Ports:
- `aclk`  in  1: clock; all logic on the rising edge.
- `areset`  in  1: reset, asynchronous and active-high.
- `s_axis_tdata`  in  `DATA_WIDTH`: input data.
- `s_axis_tvalid`  in  1: input valid.
- `s_axis_tlast`  in  1: last beat of the packet.
- `s_axis_tready`  out  1: input ready.
- `m_axis_tdata`  out  `DATA_WIDTH` x `CHANNEL_NO` (unpacked array): output data.
- `m_axis_tvalid`  out  1 x `CHANNEL_NO`: output valid.
- `m_axis_tlast`  out  1 x `CHANNEL_NO`: output last.
- `m_axis_tready`  in  1 x `CHANNEL_NO`: output ready.
- `busy`  out  1: packet in progress or output register occupied.
- `route_sel`  out  `MSEL_WIDTH`: currently locked destination.
- `pkt_cnt`  out  16: count of packets fully emitted.

## Operation
- Destination index: `dest = s_axis_tdata[DATA_WIDTH-1 -: MSEL_WIDTH]` of the header beat.
  - If `CHANNEL_NO < 2**MSEL_WIDTH` and `dest ≥ CHANNEL_NO`, the packet is consumed and discarded. It is not counted.
- FSM states:
  - `HDR`: waiting for a header beat.
  - `BODY`: routing locked to `route_sel`.
  - `DROP`: discarding a bad-destination packet.
- Transitions:
  - `HDR` → `BODY` on an accepted header with `tlast=0`.
  - `HDR` → `DROP` on an accepted header with a bad `dest` and `tlast=0`.
  - `BODY` → `HDR` and `DROP` → `HDR` on an accepted beat with `tlast=1`.
  - An accepted single-beat header (`tlast=1`) stays in `HDR`.
- Output stage: one shared register holding `out_valid`, `out_data`, `out_last`, `out_dest`.
  - `m_axis_tvalid[i] = out_valid && out_dest==i`.
  - `m_axis_tdata[i]` and `m_axis_tlast[i]` carry the register contents for all `i`. They are don't-care where valid is low.
- `s_axis_tready`:
  - In `DROP`: 1.
  - Otherwise: `!out_valid || m_axis_tready[out_dest]`. This gives full throughput when the destination stays ready.
- Handshakes follow AXI-Stream rules:
  - Outputs hold stable while valid and not ready.
  - No combinational path from `s_axis_tvalid` to `s_axis_tready`.
- `pkt_cnt` increments when a beat with `m_axis_tlast=1` handshakes on any port. It wraps 0xFFFF → 0x0000.
- `busy = (state != HDR) || out_valid`.
- Backpressure on a non-selected port never stalls the current packet. Only `m_axis_tready[out_dest]` matters.

## Timing
- Latency: an input beat accepted on cycle N appears on `m_axis_*` at cycle N+1.
- While `areset` is asserted:
  - State is `HDR`.
  - `out_valid`, `out_data`, `out_last`, `out_dest` and `route_sel` are all 0.
  - `pkt_cnt` is 0.
  - `s_axis_tready` is 0, forced low during reset.
  - All `m_axis_tvalid` are 0.
- First cycle after deassertion: `s_axis_tready` is 1.
- Reset mid-packet: the partial packet is abandoned with no `tlast` emitted. The next accepted beat is treated as a header.
- Simultaneous drain and load in one cycle: when the output beat handshakes and a new input beat is accepted, the register reloads and `out_valid` stays 1.
- When a packet with a different destination follows, the new header loads only after the previous register contents drain. No per-port reordering can occur.

## Configuration
- `CROSS_BAR_ROUTE_STRIP_HDR_EN` defined: the header beat is consumed and not forwarded.
  - In `HDR`, `s_axis_tready` is 1 regardless of the output register.
  - A header-only packet (`tlast=1` on the header) is discarded and not counted.
  - Payload latency stays 1 cycle.
- `CROSS_BAR_ROUTE_STRIP_HDR_EN` not defined: the header beat is forwarded as the first output beat to the selected port.

## Test plan
- Routing of a 4-beat packet, `MSEL_WIDTH=2`: header `tdata=0x8000_0001`, all readies 1 → beats appear only on port 2, one cycle after each input beat. `tlast` is on beat 4 and `pkt_cnt` becomes 1.
- Back-to-back packets to ports 0 then 3, continuous valid → zero idle input cycles. Port 3's header appears the cycle after port 0's `tlast` beat.
- Backpressure: `m_axis_tready[1]` held 0 for 5 cycles mid-packet → `s_axis_tready` is 0 for those cycles and output data stays stable. Toggling `m_axis_tready[0]` has no effect.
- Single-beat packet (header with `tlast=1`) to port 1 → one beat on port 1 with `tlast=1` and state stays `HDR`. With `CROSS_BAR_ROUTE_STRIP_HDR_EN`: nothing emitted and `pkt_cnt` unchanged.
- Reset mid-packet after 2 of 4 beats → all `m_axis_tvalid` 0 and `pkt_cnt` 0. The next beat `0x0000_00AA` is routed to port 0 as a header.
- `CHANNEL_NO=3`, `MSEL_WIDTH=2`, header `dest=3`, 3-beat packet → all beats accepted, no output valid, `pkt_cnt` unchanged. The following packet routes normally.

Source files
------------

// File: rtl/cross_bar_route_demux.sv
// cross_bar_route_demux: steers each AXI-Stream packet to one of CHANNEL_NO master ports using the dest field in its header beat.
// Latency: 1 cycle, from an accepted input beat to m_axis_* through one shared output register.
// Backpressure: s_axis_tready follows only the ready of the port the register currently targets; drop packets are always accepted.
// Option: define CROSS_BAR_ROUTE_STRIP_HDR_EN to consume header beats instead of forwarding them.
module cross_bar_route_demux #(
  parameter int MSEL_WIDTH = 1,
  parameter int CHANNEL_NO = 2**MSEL_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata [CHANNEL_NO],
  output logic [CHANNEL_NO-1:0] m_axis_tvalid,
  output logic [CHANNEL_NO-1:0] m_axis_tlast,
  input  logic [CHANNEL_NO-1:0] m_axis_tready,
  output logic                  busy,
  output logic [MSEL_WIDTH-1:0] route_sel,
  output logic [15:0]           pkt_cnt
);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                state;

  // Shared output register; one beat in flight regardless of destination.
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [MSEL_WIDTH-1:0] out_dest;

  logic [MSEL_WIDTH-1:0] hdr_dest;
  logic                  hdr_bad;
  logic                  sel_ready;
  logic                  in_acc;
  logic                  out_acc;
  logic                  load;
  logic [MSEL_WIDTH-1:0] load_dest;

  // Destination lives in the top bits of the header beat.
  assign hdr_dest = s_axis_tdata[DATA_WIDTH-1 -: MSEL_WIDTH];
  assign hdr_bad  = (32'(hdr_dest) >= 32'(CHANNEL_NO));

  // Ready of the port the output register currently targets; other ports never stall us.
  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < CHANNEL_NO; i++) begin
      if (32'(out_dest) == 32'(i)) begin
        sel_ready = m_axis_tready[i];
      end
    end
  end

  // Input ready depends only on state and output-register occupancy, never on s_axis_tvalid.
  always_comb begin
    if (areset) begin
      s_axis_tready = 1'b0;
    end else if (state == DROP) begin
      s_axis_tready = 1'b1;
`ifdef CROSS_BAR_ROUTE_STRIP_HDR_EN
    end else if (state == HDR) begin
      s_axis_tready = 1'b1;
`endif
    end else begin
      s_axis_tready = !out_valid || sel_ready;
    end
  end

  assign in_acc  = s_axis_tvalid && s_axis_tready;
  assign out_acc = out_valid && sel_ready;

  // Decide whether the accepted beat goes into the output register.
  always_comb begin
    load = 1'b0;
    if (in_acc) begin
      case (state)
`ifdef CROSS_BAR_ROUTE_STRIP_HDR_EN
        HDR:     load = 1'b0;
`else
        HDR:     load = !hdr_bad;
`endif
        BODY:    load = 1'b1;
        default: load = 1'b0;
      endcase
    end
  end

  assign load_dest = (state == HDR) ? hdr_dest : route_sel;

  // Packet framing FSM: lock the route on the header, release it on tlast.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= HDR;
      route_sel <= '0;
    end else if (in_acc) begin
      case (state)
        HDR: begin
          if (!hdr_bad) begin
            route_sel <= hdr_dest;
          end
          if (!s_axis_tlast) begin
            state <= hdr_bad ? DROP : BODY;
          end
        end
        BODY, DROP: begin
          if (s_axis_tlast) begin
            state <= HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

  // Output register: reload on accept (even while draining), clear when drained without reload.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_dest  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= s_axis_tdata;
      out_last  <= s_axis_tlast;
      out_dest  <= load_dest;
    end else if (out_acc) begin
      out_valid <= 1'b0;
    end
  end

  // Count packets whose last beat has left on any port; wraps naturally at 16 bits.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_cnt <= '0;
    end else if (out_acc && out_last) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  // Fan the shared register out; only the targeted port sees valid.
  always_comb begin
    for (int i = 0; i < CHANNEL_NO; i++) begin
      m_axis_tvalid[i] = out_valid && (32'(out_dest) == 32'(i));
      m_axis_tdata[i]  = out_data;
      m_axis_tlast[i]  = out_last;
    end
  end

  assign busy = (state != HDR) || out_valid;

endmodule

// File: tb/tb_cross_bar_route_demux.sv
module tb_cross_bar_route_demux;

  localparam int MW = 2;
  localparam int CN = 3;
  localparam int DW = 32;

  logic          aclk     = 1'b0;
  logic          areset   = 1'b1;
  logic [DW-1:0] s_tdata  = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast  = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata [CN];
  logic [CN-1:0] m_tvalid;
  logic [CN-1:0] m_tlast;
  logic [CN-1:0] m_tready = '1;
  logic          busy;
  logic [MW-1:0] route_sel;
  logic [15:0]   pkt_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  cross_bar_route_demux #(
    .MSEL_WIDTH(MW),
    .CHANNEL_NO(CN),
    .DATA_WIDTH(DW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .busy         (busy),
    .route_sel    (route_sel),
    .pkt_cnt      (pkt_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the beat waiting on the output side, and which packet we are inside.
  logic          mv;
  logic [DW-1:0] md;
  logic          ml;
  int            mp;
  logic          in_pkt;
  logic          dropping;
  int            cur;
  int            mcnt;
  logic [MW-1:0] mrsel;

  logic m_rdy;
  logic m_acc;
  logic m_drain;
  int   m_dest;

  assign m_rdy   = !areset && (dropping || !mv || m_tready[mp]);
  assign m_acc   = s_tvalid && m_rdy;
  assign m_drain = mv && m_tready[mp];
  assign m_dest  = int'(s_tdata[DW-1 -: MW]);

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      mv <= 1'b0; md <= '0; ml <= 1'b0; mp <= 0;
      in_pkt <= 1'b0; dropping <= 1'b0; cur <= 0; mcnt <= 0; mrsel <= '0;
    end else begin
      if (m_drain) begin
        mv <= 1'b0;
        if (ml) mcnt <= (mcnt + 1) % 65536;
      end
      if (m_acc) begin
        if (!in_pkt) begin
          if (m_dest < CN) begin
            mrsel <= s_tdata[DW-1 -: MW];
            mv <= 1'b1; md <= s_tdata; ml <= s_tlast; mp <= m_dest;
          end
          if (!s_tlast) begin
            in_pkt <= 1'b1; dropping <= (m_dest >= CN); cur <= m_dest;
          end
        end else begin
          if (!dropping) begin
            mv <= 1'b1; md <= s_tdata; ml <= s_tlast; mp <= cur;
          end
          if (s_tlast) begin
            in_pkt <= 1'b0; dropping <= 1'b0;
          end
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge aclk) begin
    chk("s_tready", 32'(s_tready), 32'(m_rdy));
    chk("m_tvalid", 32'(m_tvalid), mv ? (32'd1 << mp) : 32'd0);
    if (mv) begin
      chk("m_tdata", m_tdata[mp], md);
      chk("m_tlast", 32'(m_tlast[mp]), 32'(ml));
    end
    chk("pkt_cnt", 32'(pkt_cnt), 32'(mcnt));
    chk("busy", 32'(busy), 32'(in_pkt || mv));
    chk("route_sel", 32'(route_sel), 32'(mrsel));
  end

  // Present one beat and hold it until accepted; returns at edge+1 after acceptance.
  task automatic beat(input logic [31:0] d, input logic l, output int waits);
    bit done;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    waits    = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge aclk);
      done = s_tready;
      if (!done) waits++;
      @(posedge aclk);
      #1;
      if (!done && waits > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=%0d cycles required=accept", waits);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int  w;
    bit  acc;

    // Reset state.
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_route_sel", 32'(route_sel), 32'd0);
    areset = 1'b0;
    #1;
    chk("post_rst_tready", 32'(s_tready), 32'd1);

    // 4-beat packet to port 2.
    beat(32'h8000_0001, 1'b0, w);
    chk("p2_hdr_vld", 32'(m_tvalid), 32'b100);
    chk("p2_hdr_dat", m_tdata[2], 32'h8000_0001);
    beat(32'h11, 1'b0, w);
    beat(32'h22, 1'b0, w);
    beat(32'h33, 1'b1, w);
    chk("p2_last_vld", 32'(m_tvalid), 32'b100);
    chk("p2_last_dat", m_tdata[2], 32'h33);
    chk("p2_last_tlast", 32'(m_tlast[2]), 32'd1);
    idle();
    chk("p2_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("p2_idle_busy", 32'(busy), 32'd0);

    // Bad destination (3 of 3 ports) is swallowed.
    beat(32'hC000_0000, 1'b0, w);
    chk("drop_hdr_vld", 32'(m_tvalid), 32'd0);
    chk("drop_busy", 32'(busy), 32'd1);
    beat(32'h1, 1'b0, w);
    beat(32'h2, 1'b1, w);
    chk("drop_last_vld", 32'(m_tvalid), 32'd0);
    idle();
    chk("drop_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Single-beat packet to port 1.
    beat(32'h4000_0055, 1'b1, w);
    chk("single_vld", 32'(m_tvalid), 32'b010);
    chk("single_tlast", 32'(m_tlast[1]), 32'd1);
    chk("single_route", 32'(route_sel), 32'd1);
    idle();
    chk("single_pkt_cnt", 32'(pkt_cnt), 32'd2);
    chk("single_busy", 32'(busy), 32'd0);

    // Backpressure on port 1; port 0 toggling must not matter.
    beat(32'h4000_0000, 1'b0, w);
    beat(32'h101, 1'b0, w);
    m_tready[1] = 1'b0;
    s_tdata  = 32'h102;
    s_tlast  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      m_tready[0] = k[0];
      #1;
      chk("bp_tready", 32'(s_tready), 32'd0);
      chk("bp_hold_dat", m_tdata[1], 32'h101);
      chk("bp_hold_vld", 32'(m_tvalid), 32'b010);
      @(posedge aclk);
      #1;
    end
    m_tready = '1;
    beat(32'h102, 1'b0, w);
    chk("bp_resume_dat", m_tdata[1], 32'h102);
    beat(32'h103, 1'b1, w);
    idle();
    chk("bp_pkt_cnt", 32'(pkt_cnt), 32'd3);

    // Back-to-back packets to port 0 then port 2 with no idle input cycles.
    beat(32'h0000_0000, 1'b0, w);
    chk("b2b_w0", 32'(w), 32'd0);
    beat(32'hA, 1'b1, w);
    chk("b2b_w1", 32'(w), 32'd0);
    chk("b2b_p0_last", 32'(m_tvalid), 32'b001);
    beat(32'h8000_0000, 1'b0, w);
    chk("b2b_w2", 32'(w), 32'd0);
    chk("b2b_p2_hdr", 32'(m_tvalid), 32'b100);
    beat(32'hB, 1'b1, w);
    chk("b2b_w3", 32'(w), 32'd0);
    idle();
    chk("b2b_pkt_cnt", 32'(pkt_cnt), 32'd5);

    // Reset in the middle of a packet.
    beat(32'h8000_0000, 1'b0, w);
    beat(32'h1, 1'b0, w);
    s_tvalid = 1'b0;
    areset   = 1'b1;
    #1;
    chk("midrst_vld", 32'(m_tvalid), 32'd0);
    chk("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("midrst_tready", 32'(s_tready), 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    beat(32'h0000_00AA, 1'b0, w);
    chk("midrst_new_vld", 32'(m_tvalid), 32'b001);
    chk("midrst_new_dat", m_tdata[0], 32'hAA);
    beat(32'hBB, 1'b1, w);
    idle();
    chk("midrst_pkt_cnt2", 32'(pkt_cnt), 32'd1);

    // Randomized traffic with random per-port backpressure; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge aclk);
      acc = s_tvalid && s_tready;
      @(posedge aclk);
      #1;
      if (!s_tvalid || acc) begin
        s_tvalid = ($urandom_range(3) != 0);
        s_tdata  = $urandom;
        s_tlast  = ($urandom_range(3) == 0);
      end
      for (int p = 0; p < CN; p++) m_tready[p] = ($urandom_range(3) != 0);
    end
    s_tvalid = 1'b0;
    m_tready = '1;
    repeat (4) @(posedge aclk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
